alu_seq: RTL and testbench

Parametrised sequential ALU with flag generation; successor to the combinational ALU/accumulator pair in the datapath auxiliaries. Accepts one operation through a valid/ready handshake, executes single-cycle ops in one cycle and shifts/multiply iteratively, then holds the result and `{z,c,n}` flags until the consumer takes them. It sits between the decoder/register stage and the accumulator write-back, and replaces the fixed 8-bit ALU where wider words or multi-bit shifts and multiply are needed.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_iter.sv | 72 +++++++
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: one-bit-per-step shifter and unsigned shift-add multiplier.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  hi_nz
);

  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] acc_n;
  logic [DATA_WIDTH-1:0] hi_n;
  logic [DATA_WIDTH:0]   psum;

  // Outputs are the values after the current step, so the caller can
  // register the final result on the same edge as the last step.
  always_comb begin
    acc_n = acc;
    hi_n  = hi;
    carry = 1'b0;
    psum  = {1'b0, hi} + (acc[0] ? {1'b0, mcand} : '0);
    case (op_q)
      OP_SHL: begin
        carry = acc[DATA_WIDTH-1];
        acc_n = {acc[DATA_WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry = acc[0];
        acc_n = {1'b0, acc[DATA_WIDTH-1:1]};
      end
      OP_MUL: begin
        hi_n  = psum[DATA_WIDTH:1];
        acc_n = {psum[0], acc[DATA_WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  assign result = acc_n;
  assign hi_nz  = |hi_n;

  // {hi, acc} is the product register for MUL; acc alone is the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      acc   <= '0;
      hi    <= '0;
      mcand <= '0;
    end else if (load) begin
      op_q  <= op;
      acc   <= (op == OP_MUL) ? b : a;
      hi    <= '0;
      mcand <= a;
    end else if (step) begin
      acc <= acc_n;
      hi  <= hi_n;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshake FSM, single-cycle ops and flag generation around
// the iterative shift/multiply datapath.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [2:0]            iOp,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [DATA_WIDTH-1:0] oResult,
  output logic [2:0]            oFlags,
  output logic [1:0]            oState
);

  // Handshake: a request is taken when iValid && oReady at a rising edge
  // (oReady only in IDLE); a result retires when oValid && iReady at a rising
  // edge, and oResult/oFlags are held unchanged while oValid waits.

  state_t                  state, state_n;
  logic [SHIFT_WIDTH-1:0]  cnt, cnt_n;
  logic [2:0]              op_q;
  logic                    load, step, upd, c_n;
  logic [DATA_WIDTH-1:0]   res_n;
  logic [DATA_WIDTH:0]     add_full, sub_full;
  logic [SHIFT_WIDTH-1:0]  shamt;
  logic [DATA_WIDTH-1:0]   it_res;
  logic                    it_carry, it_hi_nz;

  assign shamt    = iB[SHIFT_WIDTH-1:0];
  assign add_full = {1'b0, iA} + {1'b0, iB};
  assign sub_full = {1'b0, iA} - {1'b0, iB};

  alu_seq_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .clk    (Clock),
    .rst    (Reset),
    .load   (load),
    .step   (step),
    .op     (iOp),
    .a      (iA),
    .b      (iB),
    .result (it_res),
    .carry  (it_carry),
    .hi_nz  (it_hi_nz)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    step    = 1'b0;
    upd     = 1'b0;
    res_n   = '0;
    c_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iValid) begin
          state_n = ST_DONE;
          upd     = 1'b1;
          case (iOp)
            OP_ADD: begin
              res_n = add_full[DATA_WIDTH-1:0];
              c_n   = add_full[DATA_WIDTH];
            end
            OP_SUB: begin
              res_n = sub_full[DATA_WIDTH-1:0];
              c_n   = sub_full[DATA_WIDTH];
            end
            OP_AND: res_n = iA & iB;
            OP_OR:  res_n = iA | iB;
            OP_SHL, OP_SHR: begin
              res_n = iA;
              if (shamt != '0) begin
                state_n = ST_EXEC;
                upd     = 1'b0;
                load    = 1'b1;
                cnt_n   = shamt - 1'b1;
              end
            end
            OP_MUL: begin
              state_n = ST_EXEC;
              upd     = 1'b0;
              load    = 1'b1;
              cnt_n   = SHIFT_WIDTH'(DATA_WIDTH - 1);
            end
            default: res_n = iA;
          endcase
        end
      end
      ST_EXEC: begin
        step = 1'b1;
        if (cnt == '0) begin
          state_n = ST_DONE;
          upd     = 1'b1;
          res_n   = it_res;
          c_n     = (op_q == OP_MUL) ? it_hi_nz : it_carry;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        if (iReady) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      oResult <= '0;
      oFlags  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == ST_IDLE && iValid) op_q <= iOp;
      if (upd) begin
        oResult        <= res_n;
        oFlags[FLAG_Z] <= ~|res_n;
        oFlags[FLAG_C] <= c_n;
        oFlags[FLAG_N] <= res_n[DATA_WIDTH-1];
      end
    end
  end

  assign oReady = (state == ST_IDLE);
  assign oValid = (state == ST_DONE);
  assign oState = state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, multi-cycle corner sequences and
// random ops checked against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         Clock, Reset, iValid, oReady, oValid, iReady;
  logic [2:0]   iOp, oFlags;
  logic [W-1:0] iA, iB, oResult;
  logic [1:0]   oState;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [2:0]   flags;
    int           lat;
  } vec_t;

  vec_t         vecs[13];
  logic [W-1:0] exp_q[$];

  alu_seq #(.DATA_WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iValid  (iValid),
    .oReady  (oReady),
    .iOp     (iOp),
    .iA      (iA),
    .iB      (iB),
    .oValid  (oValid),
    .iReady  (iReady),
    .oResult (oResult),
    .oFlags  (oFlags),
    .oState  (oState)
  );

  // clock / watchdog
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model from the operation rules, using plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [2:0] f, output int lat);
    longint full;
    int     s;
    logic   c;
    s   = int'(b[2:0]);
    c   = 1'b0;
    lat = 1;
    case (op)
      OP_ADD: begin
        full = longint'(a) + longint'(b);
        r = W'(full);
        c = (full > 255);
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_SHL: begin
        r = W'(longint'(a) << s);
        if (s > 0) begin
          c   = a[W-s];
          lat = s + 1;
        end
      end
      OP_SHR: begin
        r = a >> s;
        if (s > 0) begin
          c   = a[s-1];
          lat = s + 1;
        end
      end
      OP_MUL: begin
        full = longint'(a) * longint'(b);
        r   = W'(full);
        c   = ((full >> W) != 0);
        lat = W + 1;
      end
      default: r = a;
    endcase
    f = {(r == '0), c, r[W-1]};
  endtask

  // driver: issue one op, measure latency, check result, hold under
  // backpressure for bp cycles, then retire. Called at posedge+1.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [2:0] ef,
                       input int el, input int bp);
    int           lat;
    int           guard;
    logic [W-1:0] r0, exp_r;
    logic [2:0]   f0;
    guard = 0;
    while (!oReady && guard < 40) begin
      @(posedge Clock); #1;
      guard++;
    end
    check({name, " ready"}, 32'(oReady), 32'd1);
    iOp = op; iA = a; iB = b; iValid = 1'b1;
    exp_q.push_back(er);
    @(posedge Clock); #1;
    iValid = 1'b0;
    iOp = 3'($urandom_range(0, 7));
    iA  = W'($urandom);
    iB  = W'($urandom);
    lat = 1;
    while (!oValid && lat < 40) begin
      @(posedge Clock); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(el));
    exp_r = exp_q.pop_front();
    check({name, " result"}, 32'(oResult), 32'(exp_r));
    check({name, " flags"}, 32'(oFlags), 32'(ef));
    r0 = oResult;
    f0 = oFlags;
    for (int i = 0; i < bp; i++) begin
      @(posedge Clock); #1;
      check({name, " hold"}, {20'd0, oValid, oReady, f0 ^ oFlags, r0 ^ oResult}, {20'd0, 1'b1, 1'b0, 3'd0, 8'd0});
    end
    iReady = 1'b1;
    @(posedge Clock); #1;
    iReady = 1'b0;
    check({name, " retire"}, {30'd0, oValid, oReady}, 32'b01);
  endtask

  initial begin
    logic [W-1:0] mr;
    logic [2:0]   mf;
    int           ml, seen;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 3'b001, 1};
    vecs[1]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 3'b110, 1};
    vecs[2]  = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 3'b011, 1};
    vecs[3]  = '{OP_SHL,  8'h81, 8'h01, 8'h02, 3'b010, 2};
    vecs[4]  = '{OP_SHR,  8'h80, 8'h07, 8'h01, 3'b000, 8};
    vecs[5]  = '{OP_SHL,  8'h5A, 8'h00, 8'h5A, 3'b000, 1};
    vecs[6]  = '{OP_MUL,  8'h0F, 8'h11, 8'hFF, 3'b001, 9};
    vecs[7]  = '{OP_MUL,  8'h10, 8'h10, 8'h00, 3'b110, 9};
    vecs[8]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 3'b000, 1};
    vecs[9]  = '{OP_OR,   8'h0F, 8'hF0, 8'hFF, 3'b001, 1};
    vecs[10] = '{OP_PASS, 8'h00, 8'hAB, 8'h00, 3'b100, 1};
    vecs[11] = '{OP_SHR,  8'h01, 8'hF9, 8'h00, 3'b110, 2};
    vecs[12] = '{OP_SHL,  8'h01, 8'h07, 8'h80, 3'b001, 8};

    // reset block: asserted between edges, checked before any clock edge
    Reset = 1'b0; iValid = 1'b0; iReady = 1'b0; iOp = '0; iA = '0; iB = '0;
    #2 Reset = 1'b1;
    #1 check("reset values", {19'd0, oReady, oValid, oFlags, oResult}, {19'd0, 1'b1, 1'b0, 3'd0, 8'd0});
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].flags, vecs[i].lat, i % 3);

    // async reset in IDLE clears the held result without a clock edge
    do_op("pass a5", OP_PASS, 8'hA5, 8'h00, 8'hA5, 3'b001, 1, 0);
    #3 Reset = 1'b1;
    #1 check("async reset", {19'd0, oReady, oValid, oFlags, oResult}, {19'd0, 1'b1, 1'b0, 3'd0, 8'd0});
    @(posedge Clock); #1;
    Reset = 1'b0;
    do_op("add after reset", OP_ADD, 8'h7F, 8'h01, 8'h80, 3'b001, 1, 0);

    // backpressure with a competing request held during DONE
    iOp = OP_AND; iA = 8'hF0; iB = 8'h3C; iValid = 1'b1;
    @(posedge Clock); #1;
    iOp = OP_OR; iA = 8'hFF; iB = 8'h00;
    check("bp valid", 32'(oValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      check($sformatf("bp hold%0d", i), {20'd0, oValid, oReady, oFlags, oResult},
            {20'd0, 1'b1, 1'b0, 3'b000, 8'h30});
    end
    iReady = 1'b1;
    @(posedge Clock); #1;
    iReady = 1'b0; iValid = 1'b0;
    check("bp retire", {30'd0, oValid, oReady}, 32'b01);
    @(posedge Clock); #1;
    check("bp no accept", {21'd0, oValid, oReady, oResult}, {21'd0, 1'b0, 1'b1, 8'h30});

    // reset during MUL EXEC aborts the operation
    iOp = OP_MUL; iA = 8'h0F; iB = 8'h11; iValid = 1'b1;
    @(posedge Clock); #1;
    iValid = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    #1 check("mul abort reset", {19'd0, oReady, oValid, oFlags, oResult}, {19'd0, 1'b1, 1'b0, 3'd0, 8'd0});
    @(posedge Clock); #1;
    Reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge Clock); #1;
      if (oValid) seen = 1;
    end
    check("mul abort no valid", 32'(seen), 32'd0);
    do_op("and after abort", OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000, 1, 0);

    // random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ((i % 5) == 0) ra = ((i % 10) == 0) ? 8'h00 : 8'hFF;
      model(rop, ra, rb, mr, mf, ml);
      do_op($sformatf("rand%0d", i), rop, ra, rb, mr, mf, ml, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
